mmio_uart_tx: RTL and testbench
===============================

Name: mmio_uart_tx

Overview:
- Memory-mapped UART transmitter on the store side of the single-cycle MIPS top level.
- Consumes the processor's data-memory write bus (mem_write, data address, write data).
- Buffers bytes stored to a TX address in a small FIFO and serializes them 8N1 on a TX line.
- Decodes its own address window so the top level can steer reads and suppress data-memory writes.

Parameters:
- CLKS_PER_BIT, 16, clock cycles per serial bit; legal range is 2 or more.
- FIFO_DEPTH, 8, byte FIFO entries; must be a power of two and at least 2.
- TX_ADDR, 32'h0000_0080, byte address of the TX data register (write-only).
- STAT_ADDR, 32'h0000_0084, byte address of the status/control register.

Ports:
- i_clk_w  in  1  system clock; all state updates on the rising edge.
- i_rst_w  in  1  reset, synchronous, active-high.
- i_mem_write_w  in  1  processor store strobe.
- i_data_addr_w  in  32  processor data address (ALU result).
- i_write_data_w  in  32  processor store data.
- o_rd_w  out  32  read data for STAT_ADDR; combinational.
- o_sel_w  out  1  high when i_data_addr_w is TX_ADDR or STAT_ADDR; combinational.
- o_tx_w  out  1  serial output, idle high; registered.
- o_busy_w  out  1  high when the FSM is not IDLE or the FIFO is not empty.
- o_overflow_w  out  1  sticky flag: a push was dropped because the FIFO was full.

Behaviour:
- Reset: takes effect at the next edge while i_rst_w is high and overrides everything, including mid-frame.
  - FIFO emptied (pointers and count = 0), FSM = IDLE.
  - o_tx_w = 1, o_overflow_w = 0, o_busy_w = 0, shift register and counters = 0.
- Push condition: i_mem_write_w && i_data_addr_w == TX_ADDR. On that edge, i_write_data_w[7:0] is written to the FIFO; bits [31:8] are ignored.
- Full rule: full means count == FIFO_DEPTH, evaluated before the edge.
  - Push while full with no pop in the same cycle: byte dropped, overflow set.
  - Push while full with a pop in the same cycle: push accepted, count unchanged.
- Overflow clear: a store to STAT_ADDR with write-data bit1 = 1 clears overflow. If a dropped push and a clear coincide, set wins.
- Status read: o_rd_w = {29'b0, overflow, full, busy} when i_data_addr_w == STAT_ADDR, otherwise 32'b0. A store to TX_ADDR never changes o_rd_w.
- FIFO wrap: read and write pointers are log2(FIFO_DEPTH) bits wide and wrap modulo FIFO_DEPTH. Count is log2(FIFO_DEPTH)+1 bits.
- TX FSM states: IDLE, START, DATA, STOP.
  - IDLE: if the FIFO is non-empty, pop the head into the shift register and go to START. o_tx_w = 1 while in IDLE.
  - START: o_tx_w = 0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: o_tx_w = shift[0], LSB first. Shift right every CLKS_PER_BIT cycles. After 8 bits, go to STOP.
  - STOP: o_tx_w = 1 for CLKS_PER_BIT cycles. At the end, if the FIFO is non-empty, pop and go directly to START (no idle gap); otherwise go to IDLE.
- Counters: baud counter counts 0..CLKS_PER_BIT-1 and reloads on every state change. Bit index counts 0..7.
- Latency: push at edge N means the start bit appears on o_tx_w after edge N+1. A frame is exactly 10*CLKS_PER_BIT cycles.
- A push into an empty FIFO while the FSM is busy has no effect on the current frame.

Test Plan:
- Single byte: CLKS_PER_BIT=4, reset, store 0x0000_0141 to 0x80 -> o_tx_w = 0 (start), then 1,0,0,0,0,0,1,0, then 1 (stop), each held 4 cycles (40 cycles total). o_busy_w drops one cycle after the stop bit ends.
- Back-to-back: store 0x55, 0xAA, 0x0F on 3 consecutive cycles -> 120 contiguous frame cycles with no idle gap; bytes arrive in store order.
- Overflow: DEPTH=8, 10 stores to 0x80 on consecutive cycles -> 9 bytes transmitted, the 10th is dropped. o_overflow_w = 1; reading 0x84 returns 0x0000_0007.
- Clear: store 0x2 to 0x84 while busy -> o_overflow_w = 0 next cycle; read of 0x84 returns 0x0000_0003 (full) or 0x0000_0001.
- Decode: store to 0x88, and 0x80 with i_mem_write_w = 0 -> no push and o_busy_w stays 0. o_sel_w = 0 for 0x88 and 1 for 0x80/0x84.
- Reset mid-frame: assert i_rst_w 15 cycles into a frame with 3 bytes queued -> after that edge o_tx_w = 1 and status reads 0. No further frames are sent.

Source files
------------

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx
//   Memory-mapped 8N1 UART transmitter hanging off the processor store bus.
//   Stores to TX_ADDR push the low byte into a small FIFO; an FSM drains the
//   FIFO and serializes each byte LSB first. STAT_ADDR exposes status and
//   lets software clear the sticky overflow flag (store with bit1 set).
//
// Ports
//   i_clk_w         system clock, rising edge
//   i_rst_w         synchronous active-high reset
//   i_mem_write_w   processor store strobe
//   i_data_addr_w   processor data address
//   i_write_data_w  processor store data (bits [7:0] = TX byte, bit1 = clear)
//   o_rd_w          status read data {29'b0, overflow, full, busy} at STAT_ADDR
//   o_sel_w         address hits this block's window (TX_ADDR or STAT_ADDR)
//   o_tx_w          registered serial output, idle high
//   o_busy_w        FSM active or FIFO non-empty
//   o_overflow_w    sticky: a push was dropped on a full FIFO
module mmio_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter logic [31:0] TX_ADDR      = 32'h0000_0080,
  parameter logic [31:0] STAT_ADDR    = 32'h0000_0084
) (
  input  logic        i_clk_w,
  input  logic        i_rst_w,
  input  logic        i_mem_write_w,
  input  logic [31:0] i_data_addr_w,
  input  logic [31:0] i_write_data_w,
  output logic [31:0] o_rd_w,
  output logic        o_sel_w,
  output logic        o_tx_w,
  output logic        o_busy_w,
  output logic        o_overflow_w
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int BAUD_W = $clog2(CLKS_PER_BIT);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t            state_q, state_d;
  logic [7:0]        fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wptr_q, rptr_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [7:0]        shift_q, shift_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic              tx_q, tx_d;
  logic              ovf_q;

  logic hit_tx, hit_stat, push_req, clr_req;
  logic fifo_empty, fifo_full, baud_done, pop, push_ok, drop, busy;

  // Only the low byte is transmitted; the upper store bits are don't-care.
  logic unused_wdata;
  assign unused_wdata = ^i_write_data_w[31:8];

  assign hit_tx     = (i_data_addr_w == TX_ADDR);
  assign hit_stat   = (i_data_addr_w == STAT_ADDR);
  assign push_req   = i_mem_write_w && hit_tx;
  assign clr_req    = i_mem_write_w && hit_stat && i_write_data_w[1];
  assign fifo_empty = (cnt_q == '0);
  assign fifo_full  = (cnt_q == CNT_W'(FIFO_DEPTH));
  assign baud_done  = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));

  // A pop in the same cycle frees a slot, so a push into a full FIFO is
  // only dropped when nothing leaves.
  assign push_ok = push_req && (!fifo_full || pop);
  assign drop    = push_req && fifo_full && !pop;

  assign busy         = (state_q != IDLE) || !fifo_empty;
  assign o_busy_w     = busy;
  assign o_sel_w      = hit_tx || hit_stat;
  assign o_rd_w       = hit_stat ? {29'b0, ovf_q, fifo_full, busy} : 32'b0;
  assign o_tx_w       = tx_q;
  assign o_overflow_w = ovf_q;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge i_clk_w) begin
    if (i_rst_w) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (!fifo_empty) state_d = START;
      START: if (baud_done) state_d = DATA;
      DATA:  if (baud_done && bit_q == 3'd7) state_d = STOP;
      STOP:  if (baud_done) state_d = fifo_empty ? IDLE : START;
      default: state_d = IDLE;
    endcase
  end

  // ---------------- FSM: outputs / datapath next values ----------------
  always_comb begin
    pop     = !fifo_empty && ((state_q == IDLE) || (state_q == STOP && baud_done));
    shift_d = shift_q;
    bit_d   = bit_q;
    baud_d  = baud_done ? '0 : baud_q + BAUD_W'(1);
    if (pop) shift_d = fifo_mem[rptr_q];
    if (state_q == DATA && baud_done) begin
      if (bit_q != 3'd7) begin
        shift_d = shift_q >> 1;
        bit_d   = bit_q + 3'd1;
      end else begin
        bit_d   = 3'd0;
      end
    end
    // Baud counter restarts on every state change and is parked in IDLE.
    if (state_d != state_q || state_q == IDLE) baud_d = '0;
    // tx is registered from the next state so it lines up with that state.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge i_clk_w) begin
    if (i_rst_w) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      shift_q <= '0;
      baud_q  <= '0;
      bit_q   <= '0;
      tx_q    <= 1'b1;
      ovf_q   <= 1'b0;
    end else begin
      shift_q <= shift_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      if (push_ok) wptr_q <= wptr_q + PTR_W'(1);
      if (pop)     rptr_q <= rptr_q + PTR_W'(1);
      case ({push_ok, pop})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
      // A dropped push takes priority over a simultaneous clear.
      if (drop)         ovf_q <= 1'b1;
      else if (clr_req) ovf_q <= 1'b0;
    end
  end

  // FIFO storage needs no reset; pointers and count define validity.
  always_ff @(posedge i_clk_w) begin
    if (!i_rst_w && push_ok) fifo_mem[wptr_q] <= i_write_data_w[7:0];
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx
//   Self-checking bench for mmio_uart_tx (CLKS_PER_BIT=4, FIFO_DEPTH=8).
//   A timeline model (byte queue + position inside the current frame) gives
//   the expected tx/busy/overflow/status every cycle; hand sequences check
//   fixed waveforms and status values from the UART framing rules.
module tb_mmio_uart_tx;
  localparam int CPB   = 4;
  localparam int DEPTH = 8;
  localparam int FRAME = 10 * CPB;

  logic        clk = 1'b0;
  logic        rst, mem_write;
  logic [31:0] addr, wdata, rd;
  logic        sel, tx, busy, ovf;

  mmio_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .i_clk_w(clk), .i_rst_w(rst), .i_mem_write_w(mem_write),
    .i_data_addr_w(addr), .i_write_data_w(wdata),
    .o_rd_w(rd), .o_sel_w(sel), .o_tx_w(tx), .o_busy_w(busy),
    .o_overflow_w(ovf)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;

  // reference model
  logic [7:0] mq[$];
  bit         m_act = 0;
  int         m_pos = 0;
  logic [7:0] m_cur = 8'h00;
  bit         m_ovf = 0;

  logic       txlog[$];
  logic [7:0] rxq[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    else n_pass++;
  endtask

  task automatic model_edge(input logic we, input logic [31:0] a, input logic [31:0] d, input logic r);
    int  pre;
    bit  pop, push, clr;
    if (r) begin
      mq.delete(); m_act = 0; m_pos = 0; m_ovf = 0;
      return;
    end
    push = we && a == 32'h80;
    clr  = we && a == 32'h84 && d[1];
    pre  = mq.size();
    pop  = pre > 0 && (!m_act || m_pos == FRAME - 1);
    if (pop) begin
      m_cur = mq.pop_front(); m_act = 1; m_pos = 0;
    end else if (m_act) begin
      if (m_pos == FRAME - 1) m_act = 0;
      else m_pos++;
    end
    if (clr) m_ovf = 0;
    if (push) begin
      if (pre == DEPTH && !pop) m_ovf = 1;
      else mq.push_back(d[7:0]);
    end
  endtask

  function automatic logic exp_tx();
    int k;
    if (!m_act) return 1'b1;
    k = m_pos / CPB;
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return m_cur[k-1];
  endfunction

  // One clock: drive, edge, update model, compare every output.
  task automatic cyc(input logic we, input logic [31:0] a, input logic [31:0] d, input logic r);
    logic mb;
    mem_write = we; addr = a; wdata = d; rst = r;
    @(posedge clk);
    model_edge(we, a, d, r);
    #1;
    mb = m_act || mq.size() > 0;
    chk("tx", {31'b0, tx}, {31'b0, exp_tx()});
    chk("busy", {31'b0, busy}, {31'b0, mb});
    chk("ovf", {31'b0, ovf}, {31'b0, m_ovf});
    chk("sel", {31'b0, sel}, {31'b0, (a == 32'h80 || a == 32'h84)});
    chk("rd", rd, (a == 32'h84) ? {29'b0, m_ovf, (mq.size() == DEPTH), mb} : 32'b0);
    txlog.push_back(tx);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 32'h0, 32'h0, 1'b0);
  endtask

  // Decode 8N1 frames from the tx log by mid-bit sampling.
  task automatic decode(input int from, input int to);
    int p;
    logic [7:0] b;
    rxq.delete();
    p = from;
    while (p + FRAME <= to) begin
      if (txlog[p] == 1'b0) begin
        for (int k = 0; k < 8; k++) b[k] = txlog[p + (1 + k) * CPB + CPB / 2];
        chk("stop_bit", {31'b0, txlog[p + 9 * CPB + CPB / 2]}, 32'd1);
        rxq.push_back(b);
        p += FRAME;
      end else p++;
    end
  endtask

  typedef struct {
    logic        we;
    logic [31:0] a, d;
    logic        sel, busy;
    logic [31:0] rd;
  } vec_t;

  initial begin
    vec_t vt[6];
    int   pat[10];
    int   idx, n;
    logic [7:0] bb[3];
    logic we, r;
    logic [31:0] a;

    vt[0] = '{1'b1, 32'h88, 32'h41, 1'b0, 1'b0, 32'h0};
    vt[1] = '{1'b0, 32'h80, 32'h41, 1'b1, 1'b0, 32'h0};
    vt[2] = '{1'b0, 32'h84, 32'h00, 1'b1, 1'b0, 32'h0};
    vt[3] = '{1'b1, 32'h84, 32'h02, 1'b1, 1'b0, 32'h0};
    vt[4] = '{1'b1, 32'h81, 32'h41, 1'b0, 1'b0, 32'h0};
    vt[5] = '{1'b1, 32'h180, 32'h41, 1'b0, 1'b0, 32'h0};

    // reset state
    cyc(1'b0, 32'h0, 32'h0, 1'b1);
    cyc(1'b0, 32'h0, 32'h0, 1'b1);
    chk("rst_tx", {31'b0, tx}, 32'd1);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_ovf", {31'b0, ovf}, 32'd0);

    // address decode table: nothing here may push
    for (int i = 0; i < 6; i++) begin
      cyc(vt[i].we, vt[i].a, vt[i].d, 1'b0);
      chk("dec_sel", {31'b0, sel}, {31'b0, vt[i].sel});
      chk("dec_rd", rd, vt[i].rd);
      chk("dec_busy", {31'b0, busy}, {31'b0, vt[i].busy});
    end
    idle(3);
    chk("dec_nopush", {31'b0, busy}, 32'd0);

    // single byte 0x41 (upper store bits ignored)
    pat = '{0, 1, 0, 0, 0, 0, 0, 1, 0, 1};
    idx = txlog.size();
    cyc(1'b1, 32'h80, 32'h0000_0141, 1'b0);
    for (int i = 0; i < 41; i++) begin
      cyc(1'b0, 32'h0, 32'h0, 1'b0);
      if (i == 39) chk("single_busy_last", {31'b0, busy}, 32'd1);
      if (i == 40) chk("single_busy_drop", {31'b0, busy}, 32'd0);
    end
    for (int i = 0; i < FRAME; i++) chk("single_wave", {31'b0, txlog[idx + 1 + i]}, pat[i / CPB]);

    // back-to-back frames with no idle gap
    bb = '{8'h55, 8'hAA, 8'h0F};
    idx = txlog.size();
    for (int i = 0; i < 3; i++) cyc(1'b1, 32'h80, {24'h0, bb[i]}, 1'b0);
    idle(125);
    for (int f = 0; f < 3; f++) begin
      chk("b2b_start", {31'b0, txlog[idx + 1 + f * FRAME + CPB / 2]}, 32'd0);
      for (int k = 0; k < 8; k++)
        chk("b2b_bit", {31'b0, txlog[idx + 1 + f * FRAME + (1 + k) * CPB + CPB / 2]}, {31'b0, bb[f][k]});
    end

    // overflow: 10 pushes, 9 accepted
    idx = txlog.size();
    for (int i = 0; i < 10; i++) cyc(1'b1, 32'h80, 32'h10 + i, 1'b0);
    cyc(1'b0, 32'h84, 32'h0, 1'b0);
    chk("ovf_flag", {31'b0, ovf}, 32'd1);
    chk("ovf_stat", rd, 32'h7);
    cyc(1'b1, 32'h84, 32'h2, 1'b0);
    chk("clr_flag", {31'b0, ovf}, 32'd0);
    chk("clr_stat", {31'b0, (rd == 32'h3 || rd == 32'h1)}, 32'd1);
    n = 0;
    while (busy && n < 1000) begin
      cyc(1'b0, 32'h0, 32'h0, 1'b0);
      n++;
    end
    chk("drain_timeout", {31'b0, busy}, 32'd0);
    decode(idx, txlog.size());
    chk("ovf_nbytes", rxq.size(), 32'd9);
    for (int i = 0; i < rxq.size() && i < 9; i++) chk("ovf_byte", {24'h0, rxq[i]}, 32'h10 + i);

    // reset mid-frame with bytes queued
    for (int i = 0; i < 3; i++) cyc(1'b1, 32'h80, 32'hC3 + i, 1'b0);
    idle(13);
    cyc(1'b0, 32'h84, 32'h0, 1'b1);
    chk("rstmid_tx", {31'b0, tx}, 32'd1);
    chk("rstmid_stat", rd, 32'h0);
    idx = txlog.size();
    idle(100);
    decode(idx, txlog.size());
    chk("rstmid_noframes", rxq.size(), 32'd0);
    chk("rstmid_busy", {31'b0, busy}, 32'd0);

    // randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      we = ($urandom_range(0, 99) < 15);
      case ($urandom_range(0, 3))
        0: a = 32'h80;
        1: a = 32'h84;
        2: a = 32'h88;
        default: a = $urandom();
      endcase
      r = ($urandom_range(0, 999) == 0);
      cyc(we, a, $urandom(), r);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
